uart_tx_arbiter: RTL and testbench

//  Shares one serial UART transmit line among NUM_REQ byte requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one serial transmit line
// among NUM_REQ byte requesters. Frame = start(0), 8 data bits LSB-first,
// optional even parity, stop(1), then GAP_BITS idle-high cycles; one bit per clk.
// Optional feature macro: UART_TX_ARB_PARITY_EN (adds a parity bit after DATA).
//
// Handshake: a requester raises req[i] with its byte on data_in[8*i +: 8] and
// holds both until it sees ack[i] high for exactly one cycle; that cycle is the
// start bit of its frame. Dropping req[i] before ack means it is never served.
//
// Arbitration happens in IDLE and also on the final cycle of every frame, so
// requesters held high get back-to-back frames spaced 10(+1)+GAP_BITS cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int GAP_BITS = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*8-1:0]         data_in,
    output logic [NUM_REQ-1:0]           ack,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         serial_out,
    output logic [2:0]                   state_dbg
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [3:0] GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t           state_q, state_n;
    logic [7:0]       shift_q, shift_n;
    logic [2:0]       bit_q, bit_n;
    logic [3:0]       gap_q, gap_n;
    logic [IDW-1:0]   rr_q, rr_n;
    logic [IDW-1:0]   grant_q, grant_n;
    logic [NUM_REQ-1:0] ack_q, ack_n;
    logic             busy_q, busy_n;
    logic             serial_q, serial_n;
`ifdef UART_TX_ARB_PARITY_EN
    logic             par_q, par_n;
`endif

    // Winner search: first set req bit starting at rr+1, wrapping at NUM_REQ.
    logic             win_found;
    logic [IDW-1:0]   win_id;
    int               cand;

    // Scan from farthest to nearest so the nearest candidate after rr wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = int'(rr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IDW-1:0];
            end
        end
    end

    // Next-state and next-output logic; every output is taken from a register.
    logic arb_now;
    always_comb begin
        state_n  = state_q;
        shift_n  = shift_q;
        bit_n    = bit_q;
        gap_n    = gap_q;
        rr_n     = rr_q;
        grant_n  = grant_q;
        ack_n    = '0;
        busy_n   = busy_q;
        serial_n = serial_q;
        arb_now  = 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
        par_n    = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                serial_n = 1'b1;
                busy_n   = 1'b0;
                arb_now  = 1'b1;
            end
            S_START: begin
                state_n  = S_DATA;
                serial_n = shift_q[0];
                shift_n  = shift_q >> 1;
                bit_n    = 3'd0;
            end
            S_DATA: begin
                if (bit_q == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
                    state_n  = S_PARITY;
                    serial_n = par_q;
`else
                    state_n  = S_STOP;
                    serial_n = 1'b1;
`endif
                end else begin
                    serial_n = shift_q[0];
                    shift_n  = shift_q >> 1;
                    bit_n    = bit_q + 3'd1;
                end
            end
`ifdef UART_TX_ARB_PARITY_EN
            S_PARITY: begin
                state_n  = S_STOP;
                serial_n = 1'b1;
            end
`endif
            S_STOP: begin
                if (GAP_BITS == 0) begin
                    arb_now = 1'b1;
                end else begin
                    state_n  = S_GAP;
                    gap_n    = 4'd0;
                    serial_n = 1'b1;
                end
            end
            S_GAP: begin
                serial_n = 1'b1;
                if (gap_q == GAP_LAST) begin
                    arb_now = 1'b1;
                end else begin
                    gap_n = gap_q + 4'd1;
                end
            end
            default: begin
                state_n  = S_IDLE;
                serial_n = 1'b1;
                busy_n   = 1'b0;
            end
        endcase

        // Arbitration slot: either start the winner's frame or fall idle.
        if (arb_now) begin
            if (win_found) begin
                state_n        = S_START;
                shift_n        = data_in[8*win_id +: 8];
                ack_n[win_id]  = 1'b1;
                grant_n        = win_id;
                rr_n           = win_id;
                serial_n       = 1'b0;
                busy_n         = 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
                par_n          = ^data_in[8*win_id +: 8];
`endif
            end else begin
                state_n  = S_IDLE;
                serial_n = 1'b1;
                busy_n   = 1'b0;
            end
        end
    end

    // State and output registers; reset puts the line idle and rr so req 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shift_q  <= 8'd0;
            bit_q    <= 3'd0;
            gap_q    <= 4'd0;
            rr_q     <= IDW'(NUM_REQ - 1);
            grant_q  <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            serial_q <= 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            shift_q  <= shift_n;
            bit_q    <= bit_n;
            gap_q    <= gap_n;
            rr_q     <= rr_n;
            grant_q  <= grant_n;
            ack_q    <= ack_n;
            busy_q   <= busy_n;
            serial_q <= serial_n;
`ifdef UART_TX_ARB_PARITY_EN
            par_q    <= par_n;
`endif
        end
    end

    assign ack        = ack_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign serial_out = serial_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: main instance with GAP_BITS=1 and a
// second instance with GAP_BITS=0 for back-to-back frames.
module tb_uart_tx_arbiter;

    localparam int GAP = 1;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F0 = 10 + PAR;

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main DUT signals
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic        serial_out;
    logic [2:0]  state_dbg;

    // Zero-gap DUT signals
    logic [3:0]  req0;
    logic [31:0] data0;
    logic [3:0]  ack0;
    logic [1:0]  grant0;
    logic        busy0;
    logic        serial0;
    logic [2:0]  state0;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_BITS(GAP)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in), .ack(ack),
        .grant_id(grant_id), .busy(busy), .serial_out(serial_out), .state_dbg(state_dbg)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_BITS(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .data_in(data0), .ack(ack0),
        .grant_id(grant0), .busy(busy0), .serial_out(serial0), .state_dbg(state0)
    );

    // Scoreboard: expected {busy, line} per cycle
    logic [1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input logic [7:0] b, input int gap);
        exp_q.push_back(2'b10);
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, b[i]});
        if (PAR == 1) exp_q.push_back({1'b1, ^b});
        exp_q.push_back(2'b11);
        for (int g = 0; g < gap; g++) exp_q.push_back(2'b11);
    endtask

    // Pops one expectation per cycle; leaves time at the last frame cycle.
    task automatic drain(input string tag, input logic [3:0] first_ack);
        int n;
        logic [1:0] e;
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_line"}, {30'd0, busy, serial_out}, {30'd0, e});
            chk({tag, "_ack"}, {28'd0, ack}, (n == 0) ? {28'd0, first_ack} : 32'd0);
            n++;
            if (exp_q.size() > 0) tick();
        end
    endtask

    logic [7:0] bytes_a [4];
    int         ord [9];

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_a = '{8'h10, 8'h21, 8'h32, 8'h43};
        ord     = '{0, 1, 2, 3, 0, 1, 2, 0, 2};
        reset   = 1'b1;
        req     = 4'd0;
        data_in = 32'd0;
        req0    = 4'd0;
        data0   = 32'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_line",  serial_out, 1);
        chk("rst_busy",  busy, 0);
        chk("rst_ack",   ack, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst_line0", serial0, 1);
        reset = 1'b0;

        // Idle with no requests
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_line", serial_out, 1);
            chk("idle_busy", busy, 0);
            chk("idle_ack",  ack, 0);
        end

        // Single byte 0xA5 from requester 0
        data_in[7:0] = 8'hA5;
        req = 4'b0001;
        tick();
        chk("a5_grant", grant_id, 0);
        req = 4'b0000;
        expect_frame(8'hA5, GAP);
        drain("a5", 4'b0001);
        tick();
        chk("a5_after_busy", busy, 0);
        chk("a5_after_line", serial_out, 1);

        // Reset during DATA bit 4 of 0xFF
        data_in[7:0] = 8'hFF;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        chk("ff_ack", ack, 4'b0001);
        repeat (5) tick();
        chk("ff_bit4_state", state_dbg, 2);
        chk("ff_bit4_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_line",  serial_out, 1);
        chk("mid_rst_busy",  busy, 0);
        chk("mid_rst_state", state_dbg, 0);
        tick();
        reset = 1'b0;
        data_in = {bytes_a[3], bytes_a[2], bytes_a[1], bytes_a[0]};
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_ack",  ack, 0);
            chk("post_rst_busy", busy, 0);
        end

        // Rotation with all held, then 0101 after grant 2
        req = 4'b1111;
        tick();
        for (int k = 0; k < 9; k++) begin
            chk("rr_grant", grant_id, ord[k]);
            if (k == 6) req = 4'b0101;
            if (k == 8) req = 4'b0000;
            expect_frame(bytes_a[ord[k]], GAP);
            drain("rr", 4'b0001 << ord[k]);
            tick();
        end
        chk("rr_end_busy", busy, 0);
        chk("rr_end_ack",  ack, 0);

        // Zero gap: back-to-back frames from requester 1
        data0[15:8] = 8'h00;
        req0 = 4'b0010;
        tick();
        chk("g0_grant", grant0, 1);
        expect_frame(8'h00, 0);
        expect_frame(8'h00, 0);
        for (int c = 0; c < 2 * F0; c++) begin
            logic [1:0] e;
            e = exp_q.pop_front();
            chk("g0_line", {30'd0, busy0, serial0}, {30'd0, e});
            chk("g0_ack", {28'd0, ack0}, ((c % F0) == 0) ? 32'd2 : 32'd0);
            if (c == F0) req0 = 4'b0000;
            tick();
        end
        chk("g0_end_busy", busy0, 0);
        chk("g0_end_line", serial0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
